// File: rtl/mem_pkg.sv
// Shared definitions for the parity-protected word memory and its clients.
// Holds the stored-word layout, the even-parity encode/check helpers used by
// the writer, the memory model and the reader, and the reader FSM states.
package mem_pkg;

   localparam int WORD_W   = 8;
   localparam int STORED_W = 9;

   typedef logic [STORED_W-1:0] stored_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

   // Bit 8 is chosen so that the XOR over all nine bits is 0.
   function automatic stored_word_t even_parity(input logic [WORD_W-1:0] d);
      return {^d, d};
   endfunction

   function automatic logic parity_ok(input stored_word_t w);
      return ~(^w);
   endfunction

endpackage

// File: rtl/mem_parity_reader_if.sv
// Command, memory-read and output-stream signals of mem_parity_reader.
//   start/base_addr/length : sweep command
//   busy/done/err_count    : sweep status
//   mem_read/mem_address   : read request, mem_data_out returns the next cycle
//   out_valid/out_ready    : output handshake carrying out_data/out_perr
// Modport slave is the reader; modport master is its environment.
interface mem_parity_reader_if #(
   parameter int ADDR_W = 16
);
   import mem_pkg::*;

   logic                start;
   logic [ADDR_W-1:0]   base_addr;
   logic [ADDR_W-1:0]   length;
   logic                busy;
   logic                done;
   logic                mem_read;
   logic [ADDR_W-1:0]   mem_address;
   stored_word_t        mem_data_out;
   logic                out_valid;
   logic                out_ready;
   logic [WORD_W-1:0]   out_data;
   logic                out_perr;
   logic [15:0]         err_count;

   modport slave (
      input  start, base_addr, length, mem_data_out, out_ready,
      output busy, done, mem_read, mem_address, out_valid, out_data,
             out_perr, err_count
   );

   modport master (
      output start, base_addr, length, mem_data_out, out_ready,
      input  busy, done, mem_read, mem_address, out_valid, out_data,
             out_perr, err_count
   );

endinterface

// File: rtl/parity_sync_fifo.sv
// Single-clock FIFO buffering checked words ahead of the output handshake.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   push_i, wdata_i      : write side
//   pop_i, rdata_o       : read side, rdata_o shows the head (0 when empty)
//   full_o, empty_o      : status
//   count_o              : occupancy, 0..DEPTH
// Pointers carry one extra MSB so full and empty are told apart without a
// separate counter. Storage is not reset; only the pointers are.
module parity_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_en, pop_en;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;

   // A push into a full FIFO is only safe when the head leaves the same cycle.
   assign push_en = push_i && (!full_o || pop_i);
   assign pop_en  = pop_i && !empty_o;

   assign wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = pop_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;

   // Gate the head so nothing stale is visible while empty or after reset.
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/mem_parity_reader.sv
// Sweeps a contiguous address range of the parity-protected memory, checks
// even parity on every returned word and streams {perr, data} downstream.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_parity_reader_if.slave (command, memory read, output
//                stream, busy/done/err_count status)
// A read is issued only when the FIFO can absorb every outstanding word, so
// returned data never needs to be throttled or dropped.
module mem_parity_reader
   import mem_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_parity_reader_if.slave  bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = CW + 1;

   rd_state_e          state_q, state_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [ADDR_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0]  issued_q, issued_d;
   logic [15:0]        err_q, err_d;
   logic               rd_vld_p1_q;

   logic               rd_req;
   logic               done_c;
   logic               ret_perr;
   logic               fifo_pop;
   logic               fifo_full, fifo_empty;
   logic [CW-1:0]      fifo_count;
   stored_word_t       fifo_rdata;
   logic [OW-1:0]      occupancy;
   logic               issue_ok;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Words already buffered plus the one read whose data is on the bus now.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rd_vld_p1_q};
   assign issue_ok  = !fifo_full && (occupancy < OW'(FIFO_DEPTH));

   assign ret_perr  = ~parity_ok(bus.mem_data_out);
   assign fifo_pop  = !fifo_empty && bus.out_ready;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      issued_d = issued_q;
      err_d    = err_q;
      rd_req   = 1'b0;
      done_c   = 1'b0;

      if (rd_vld_p1_q && ret_perr) err_d = sat_inc(err_q);

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               base_d   = bus.base_addr;
               len_d    = bus.length;
               issued_d = '0;
               err_d    = '0;
               // Zero length goes straight to DRAIN, which completes at once.
               state_d  = (bus.length == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (issue_ok) begin
               rd_req   = 1'b1;
               issued_d = issued_q + 1'b1;
               if (issued_q == len_q - 1'b1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!rd_vld_p1_q && fifo_empty) begin
               done_c  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      base_q <= base_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         issued_q    <= '0;
         err_q       <= '0;
         rd_vld_p1_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         err_q       <= err_d;
         rd_vld_p1_q <= rd_req;
      end
   end

   // p1: memory word returned for the read issued last cycle, pushed checked
   parity_sync_fifo #(
      .WIDTH (STORED_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (rd_vld_p1_q),
      .wdata_i ({ret_perr, bus.mem_data_out[WORD_W-1:0]}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign bus.mem_read    = rd_req;
   assign bus.mem_address = rd_req ? base_q + issued_q : '0;
   assign bus.busy        = (state_q != IDLE) && !done_c;
   assign bus.done        = done_c;
   assign bus.out_valid   = !fifo_empty;
   assign bus.out_data    = fifo_rdata[WORD_W-1:0];
   assign bus.out_perr    = fifo_rdata[STORED_W-1];
   assign bus.err_count   = err_q;

endmodule
